// File: rtl/ram_bwe_pkg.sv
// rtl/ram_bwe_pkg.sv - shared state type, constants and lane merge helper for ram_bwe
package parammod_ram_pkg;

  typedef enum logic {ST_INIT, ST_RUN} ram_state_t;

  localparam int RD_LAT_MAX = 2;
  localparam bit ENABLE     = 1'b1;
  localparam bit DISABLE    = 1'b0;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_W = 256;
  typedef logic [MERGE_W-1:0] merge_word_t;
  typedef logic [MERGE_W-1:0] merge_lanes_t;

  function automatic merge_word_t lane_merge(input merge_word_t  old_word,
                                             input merge_word_t  new_word,
                                             input merge_lanes_t be,
                                             input int           lane_w);
    merge_word_t res;
    for (int i = 0; i < MERGE_W; i++) begin
      res[i] = be[i / lane_w] ? new_word[i] : old_word[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_bwe_if.sv
// rtl/ram_bwe_if.sv - multi-port access bus for ram_bwe
interface ram_bwe_if #(
  parameter int DATA  = 32,
  parameter int BYTE  = 8,
  parameter int DEPTH = 16,
  parameter int PORT  = 2
);
  localparam int BW   = DATA / BYTE;
  localparam int ADDR = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                       ready;
  logic [PORT-1:0]            en;
  logic [PORT-1:0]            rw_;
  logic [PORT-1:0][BW-1:0]    be;
  logic [PORT-1:0][ADDR-1:0]  addr;
  logic [PORT-1:0][DATA-1:0]  wdata;
  logic [PORT-1:0][DATA-1:0]  rdata;
  logic [PORT-1:0]            rvalid;

  modport master (
    input  ready, rdata, rvalid,
    output en, rw_, be, addr, wdata
  );

  modport slave (
    output ready, rdata, rvalid,
    input  en, rw_, be, addr, wdata
  );

endinterface

// File: rtl/ram_bwe_rd_pipe.sv
// rtl/ram_bwe_rd_pipe.sv - per-port read result pipeline of 0..2 flop stages
module ram_rd_pipe #(
  parameter int DATA   = 32,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            req_valid,
  input  logic [DATA-1:0] req_data,
  output logic            rsp_valid,
  output logic [DATA-1:0] rsp_data
);

  generate
    if (RD_LAT == 0) begin : g_comb
      assign rsp_valid = req_valid;
      assign rsp_data  = req_valid ? req_data : '0;
    end else begin : g_reg
      logic [RD_LAT-1:0] vld;
      logic [DATA-1:0]   dat [RD_LAT];

      // Data is zeroed alongside valid so rdata never shows a stale word.
      always_ff @(posedge clk) begin
        if (!reset_) begin
          vld <= '0;
          for (int s = 0; s < RD_LAT; s++) begin
            dat[s] <= '0;
          end
        end else begin
          vld[0] <= req_valid;
          dat[0] <= req_valid ? req_data : '0;
          for (int s = 1; s < RD_LAT; s++) begin
            vld[s] <= vld[s-1];
            dat[s] <= dat[s-1];
          end
        end
      end

      assign rsp_valid = vld[RD_LAT-1];
      assign rsp_data  = dat[RD_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/ram_bwe.sv
// rtl/ram_bwe.sv - flop-based multi-port RAM with byte enables, forwarding and reset sweep
module ram_bwe
  import parammod_ram_pkg::*;
#(
  parameter int    DATA         = 32,
  parameter int    BYTE         = 8,
  parameter int    DEPTH        = 16,
  parameter int    PORT         = 2,
  parameter int    RD_LAT       = 1,
  parameter bit    FWD          = ENABLE,
  parameter bit    CLR_ON_RESET = ENABLE,
  parameter string MEM_FILE     = "none",
  parameter int    ADDR         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic       clk,
  input  logic       reset_,
  ram_bwe_if.slave   bus
);

  localparam int BW = DATA / BYTE;

  generate
    if (BYTE < 1 || DATA % BYTE != 0) begin : g_chk_byte
      $error("ram_bwe: DATA must be a non-zero multiple of BYTE");
    end
    if (RD_LAT < 0 || RD_LAT > RD_LAT_MAX) begin : g_chk_lat
      $error("ram_bwe: RD_LAT must be 0, 1 or 2");
    end
    if (PORT < 1) begin : g_chk_port
      $error("ram_bwe: PORT must be at least 1");
    end
    if (DATA > MERGE_W) begin : g_chk_width
      $error("ram_bwe: DATA exceeds lane merge width");
    end
    if (CLR_ON_RESET && MEM_FILE != "none") begin : g_chk_image
      $warning("ram_bwe: MEM_FILE image is overwritten by the reset sweep");
    end
  endgenerate

  function automatic logic [DATA-1:0] merge(input logic [DATA-1:0] old_word,
                                            input logic [DATA-1:0] new_word,
                                            input logic [BW-1:0]   lanes);
    return DATA'(lane_merge(merge_word_t'(old_word), merge_word_t'(new_word),
                            merge_lanes_t'(lanes), BYTE));
  endfunction

  ram_state_t                state;
  ram_state_t                state_nxt;
  logic [ADDR-1:0]           clr_ptr;
  logic [ADDR-1:0]           clr_nxt;
  logic                      clr_en;
  logic                      ready;

  logic [PORT-1:0]           ren;
  logic [PORT-1:0]           wen;
  logic [PORT-1:0]           addr_ok;
  logic [PORT-1:0][DATA-1:0] rd_word;
  logic [PORT-1:0]           rvalid;
  logic [PORT-1:0][DATA-1:0] rdata;

  logic [DATA-1:0]           mem     [DEPTH];
  logic [DATA-1:0]           mem_nxt [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state   <= ST_INIT;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: begin
        if (!CLR_ON_RESET || clr_ptr == ADDR'(DEPTH - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    ready   = (state == ST_RUN);
    clr_en  = CLR_ON_RESET && reset_ && (state == ST_INIT);
    clr_nxt = clr_ptr;
    if (clr_en) begin
      clr_nxt = (clr_ptr == ADDR'(DEPTH - 1)) ? '0 : clr_ptr + ADDR'(1);
    end
  end

  assign bus.ready = ready;

  // Writes are also gated by reset_ so an access in the reset cycle is dropped.
  always_comb begin
    for (int p = 0; p < PORT; p++) begin
      addr_ok[p] = 32'(bus.addr[p]) < DEPTH;
      ren[p]     = ready & bus.en[p] & bus.rw_[p];
      wen[p]     = ready & reset_ & bus.en[p] & ~bus.rw_[p];
    end
  end

  // Ports are applied in index order so the highest port owns a contested lane.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      mem_nxt[e] = mem[e];
      for (int p = 0; p < PORT; p++) begin
        if (wen[p] && addr_ok[p] && bus.addr[p] == ADDR'(e)) begin
          mem_nxt[e] = merge(mem_nxt[e], bus.wdata[p], bus.be[p]);
        end
      end
      if (clr_en && clr_ptr == ADDR'(e)) begin
        mem_nxt[e] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      mem[e] <= mem_nxt[e];
    end
  end

  always_comb begin
    for (int p = 0; p < PORT; p++) begin
      rd_word[p] = '0;
      if (ren[p] && addr_ok[p]) begin
        rd_word[p] = mem[bus.addr[p]];
        if (FWD) begin
          for (int q = 0; q < PORT; q++) begin
            if (wen[q] && bus.addr[q] == bus.addr[p]) begin
              rd_word[p] = merge(rd_word[p], bus.wdata[q], bus.be[q]);
            end
          end
        end
      end
    end
  end

  generate
    for (genvar p = 0; p < PORT; p++) begin : g_port
      ram_rd_pipe #(
        .DATA   (DATA),
        .RD_LAT (RD_LAT)
      ) u_rd_pipe (
        .clk       (clk),
        .reset_    (reset_),
        .req_valid (ren[p]),
        .req_data  (rd_word[p]),
        .rsp_valid (rvalid[p]),
        .rsp_data  (rdata[p])
      );
    end
  endgenerate

  assign bus.rvalid = rvalid;
  assign bus.rdata  = rdata;

endmodule

// File: tb/tb_ram_bwe.sv
// tb/tb_ram_bwe.sv - scoreboard bench for ram_bwe across three configurations
module tb_ram_bwe;
  import parammod_ram_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_on = 1'b0;

  // dut 0: DEPTH 16, RD_LAT 1, FWD, sweep; dut 1: DEPTH 12, RD_LAT 2, no FWD, no sweep;
  // dut 2: DEPTH 12, RD_LAT 0, FWD, no sweep.
  int lat [3] = '{1, 2, 0};

  logic [1:0]       d_en    [3];
  logic [1:0]       d_rw    [3];
  logic [1:0][3:0]  d_be    [3];
  logic [1:0][3:0]  d_addr  [3];
  logic [1:0][31:0] d_wdata [3];
  logic [1:0]       m_rvalid [3];
  logic [1:0][31:0] m_rdata  [3];

  exp_t exp_q [3][2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_bwe_if #(.DATA(32), .BYTE(8), .DEPTH(16), .PORT(2)) bus_a ();
  ram_bwe_if #(.DATA(32), .BYTE(8), .DEPTH(12), .PORT(2)) bus_b ();
  ram_bwe_if #(.DATA(32), .BYTE(8), .DEPTH(12), .PORT(2)) bus_c ();

  ram_bwe #(.DATA(32), .BYTE(8), .DEPTH(16), .PORT(2), .RD_LAT(1),
            .FWD(ENABLE), .CLR_ON_RESET(ENABLE), .MEM_FILE("none"))
    dut_a (.clk(clk), .reset_(reset_), .bus(bus_a));
  ram_bwe #(.DATA(32), .BYTE(8), .DEPTH(12), .PORT(2), .RD_LAT(2),
            .FWD(DISABLE), .CLR_ON_RESET(DISABLE), .MEM_FILE("none"))
    dut_b (.clk(clk), .reset_(reset_), .bus(bus_b));
  ram_bwe #(.DATA(32), .BYTE(8), .DEPTH(12), .PORT(2), .RD_LAT(0),
            .FWD(ENABLE), .CLR_ON_RESET(DISABLE), .MEM_FILE("none"))
    dut_c (.clk(clk), .reset_(reset_), .bus(bus_c));

  assign bus_a.en = d_en[0];    assign bus_b.en = d_en[1];    assign bus_c.en = d_en[2];
  assign bus_a.rw_ = d_rw[0];   assign bus_b.rw_ = d_rw[1];   assign bus_c.rw_ = d_rw[2];
  assign bus_a.be = d_be[0];    assign bus_b.be = d_be[1];    assign bus_c.be = d_be[2];
  assign bus_a.addr = d_addr[0]; assign bus_b.addr = d_addr[1]; assign bus_c.addr = d_addr[2];
  assign bus_a.wdata = d_wdata[0]; assign bus_b.wdata = d_wdata[1]; assign bus_c.wdata = d_wdata[2];
  assign m_rvalid[0] = bus_a.rvalid; assign m_rvalid[1] = bus_b.rvalid; assign m_rvalid[2] = bus_c.rvalid;
  assign m_rdata[0] = bus_a.rdata;   assign m_rdata[1] = bus_b.rdata;   assign m_rdata[2] = bus_c.rdata;

  task automatic clear_all();
    for (int d = 0; d < 3; d++) begin
      d_en[d] = '0; d_rw[d] = '0; d_be[d] = '0; d_addr[d] = '0; d_wdata[d] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_all();
  endtask

  task automatic wr(input int d, input int p, input logic [3:0] a,
                    input logic [31:0] data, input logic [3:0] be);
    d_en[d][p] = 1'b1; d_rw[d][p] = 1'b0; d_addr[d][p] = a;
    d_wdata[d][p] = data; d_be[d][p] = be;
  endtask

  task automatic rd(input int d, input int p, input logic [3:0] a,
                    input logic [31:0] data, input bit expect_rsp);
    exp_t e;
    d_en[d][p] = 1'b1; d_rw[d][p] = 1'b1; d_addr[d][p] = a;
    if (expect_rsp) begin
      e.data = data;
      e.due  = cyc + lat[d];
      exp_q[d][p].push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < 3; d++) begin
        for (int p = 0; p < 2; p++) begin
          total++;
          if (m_rvalid[d][p] === 1'b1) begin
            if (exp_q[d][p].size() == 0) begin
              bad++;
              $display("FAIL spurious_rvalid dut%0d port%0d cyc %0d: got %h, want no response",
                       d, p, cyc, m_rdata[d][p]);
            end else begin
              exp_t e;
              e = exp_q[d][p].pop_front();
              if (m_rdata[d][p] !== e.data || cyc != e.due) begin
                bad++;
                $display("FAIL read dut%0d port%0d: got %h at cyc %0d, want %h at cyc %0d",
                         d, p, m_rdata[d][p], cyc, e.data, e.due);
              end
            end
          end else begin
            if (m_rvalid[d][p] !== 1'b0 || m_rdata[d][p] !== 32'h0) begin
              bad++;
              $display("FAIL idle_output dut%0d port%0d cyc %0d: got rvalid %b rdata %h, want 0/0",
                       d, p, cyc, m_rvalid[d][p], m_rdata[d][p]);
            end else if (exp_q[d][p].size() != 0 && exp_q[d][p][0].due <= cyc) begin
              bad++;
              $display("FAIL missing_rvalid dut%0d port%0d cyc %0d: got none, want %h",
                       d, p, cyc, exp_q[d][p][0].data);
              void'(exp_q[d][p].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] pre [4];
    pre = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    clear_all();
    reset_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    tick();
    check("reset_ready_a", 32'(bus_a.ready), 32'd0);
    check("reset_ready_b", 32'(bus_b.ready), 32'd0);

    // Initial sweep; a write during the sweep must be dropped.
    reset_ = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) wr(0, 0, 4'd0, 32'hDEADBEEF, 4'hF);
      tick();
      check($sformatf("ready_a_edge%0d", i), 32'(bus_a.ready), (i == 16) ? 32'd1 : 32'd0);
    end
    check("ready_b_run", 32'(bus_b.ready), 32'd1);
    check("ready_c_run", 32'(bus_c.ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      rd(0, 0, 4'(i), 32'h0, 1'b1);
      rd(0, 1, 4'(15 - i), 32'h0, 1'b1);
      tick();
    end

    // Byte lanes
    wr(0, 0, 4'd3, 32'hAABBCCDD, 4'b1111); tick();
    wr(0, 0, 4'd3, 32'h11223344, 4'b0101); tick();
    rd(0, 0, 4'd3, 32'hAA22CC44, 1'b1); tick();

    // Same-cycle forwarding, full and partial lanes
    wr(0, 0, 4'd5, 32'h12345678, 4'b1111); rd(0, 1, 4'd5, 32'h12345678, 1'b1); tick();
    wr(0, 0, 4'd5, 32'hFFFFFFFF, 4'b0011); rd(0, 1, 4'd5, 32'h1234FFFF, 1'b1); tick();

    // Write-write conflict
    wr(0, 0, 4'd7, 32'h0000FFFF, 4'b1111); wr(0, 1, 4'd7, 32'hFFFF0000, 4'b1111); tick();
    rd(0, 0, 4'd7, 32'hFFFF0000, 1'b1); tick();
    wr(0, 0, 4'd7, 32'h0000FFFF, 4'b1111); wr(0, 1, 4'd7, 32'hFFFF0000, 4'b1100); tick();
    rd(0, 0, 4'd7, 32'hFFFFFFFF, 1'b1); tick();

    // Pipelined read-after-write
    wr(0, 1, 4'd9, 32'hCAFEF00D, 4'b1111); tick();
    rd(0, 0, 4'd9, 32'hCAFEF00D, 1'b1); tick();

    // Latency sweep on dut 1 (RD_LAT 2) and dut 2 (RD_LAT 0)
    for (int d = 1; d <= 2; d++) begin
      wr(d, 0, 4'd0, pre[0], 4'hF); wr(d, 1, 4'd1, pre[1], 4'hF);
    end
    tick();
    for (int d = 1; d <= 2; d++) begin
      wr(d, 0, 4'd2, pre[2], 4'hF); wr(d, 1, 4'd3, pre[3], 4'hF);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      for (int d = 1; d <= 2; d++) begin
        rd(d, 0, 4'(i), pre[i], 1'b1);
        rd(d, 1, 4'(3 - i), pre[3 - i], 1'b1);
      end
      tick();
    end
    tick();
    for (int d = 1; d <= 2; d++) rd(d, 0, 4'd1, pre[1], 1'b1);
    tick();

    // Collision without / with forwarding
    for (int d = 1; d <= 2; d++) begin
      wr(d, 0, 4'd2, 32'h12345678, 4'hF);
      rd(d, 1, 4'd2, (d == 1) ? pre[2] : 32'h12345678, 1'b1);
    end
    tick();
    for (int d = 1; d <= 2; d++) rd(d, 0, 4'd2, 32'h12345678, 1'b1);
    tick();

    // Out-of-range address
    for (int d = 1; d <= 2; d++) begin
      wr(d, 0, 4'd13, 32'hFFFFFFFF, 4'hF);
      rd(d, 1, 4'd12, 32'h0, 1'b1);
    end
    tick();
    for (int d = 1; d <= 2; d++) begin
      rd(d, 0, 4'd13, 32'h0, 1'b1);
      rd(d, 1, 4'd1, pre[1], 1'b1);
    end
    tick();
    repeat (3) tick();

    // Reset with reads in flight and a write in the reset cycle
    rd(0, 0, 4'd7, 32'hFFFFFFFF, 1'b1);
    rd(1, 0, 4'd0, 32'h0, 1'b0);
    tick();
    reset_ = 1'b0;
    wr(1, 0, 4'd0, 32'hBAD0BAD0, 4'hF);
    tick();
    reset_ = 1'b1;
    check("ready_a_after_reset", 32'(bus_a.ready), 32'd0);

    // Reset again at sweep cycle 8: full sweep restarts
    repeat (8) tick();
    reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("ready_a_resweep_edge%0d", i), 32'(bus_a.ready), (i == 16) ? 32'd1 : 32'd0);
    end
    check("ready_b_after_reset", 32'(bus_b.ready), 32'd1);

    rd(0, 0, 4'd3, 32'h0, 1'b1);
    rd(0, 1, 4'd7, 32'h0, 1'b1);
    rd(1, 0, 4'd0, pre[0], 1'b1);
    rd(2, 0, 4'd1, pre[1], 1'b1);
    tick();
    repeat (4) tick();

    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("drain_dut%0d_port%0d", d, p), 32'(exp_q[d][p].size()), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
